// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the serial instruction-memory loader:
// receive FSM state encodings and byte/word geometry.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_uart_loader_uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer plus receive FSM; byte_valid and
// framing_err are single-cycle pulses issued in the stop-bit sample cycle.
module uart_rx_8n1
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rx,
  output logic                  byte_valid,
  output logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  framing_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  r_rx_prev;
  logic [BAUD_W-1:0]     r_baud;
  logic [BAUD_W-1:0]     w_baud_nxt;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_nxt;
  logic [BYTE_WIDTH-1:0] r_shift;
  logic [BYTE_WIDTH-1:0] w_shift_nxt;
  logic                  w_baud_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign byte_data   = r_shift;

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (r_rx_prev && !r_rx_sync) w_state_nxt = START;
      end
      START: begin
        if (r_baud == BAUD_HALF) begin
          w_baud_nxt  = '0;
          w_state_nxt = r_rx_sync ? IDLE : DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      DATA: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {r_rx_sync, r_shift[BYTE_WIDTH-1:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = STOP;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          if (r_rx_sync) begin
            byte_valid  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            framing_err = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (r_rx_sync) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Leaving load mode abandons any byte in flight.
    if (!enable) begin
      w_state_nxt = IDLE;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
      byte_valid  = 1'b0;
      framing_err = 1'b0;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial program loader: packs UART bytes big-endian into 32-bit words and
// strobes them into instruction memory at word addresses 0..MEMORY_SIZE-1.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEMORY_SIZE  = 43
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        write_enabled,
  output logic [31:0] word_count,
  output logic        done,
  output logic        err_framing,
  output logic        err_overflow
);

  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

  logic                  w_byte_valid;
  logic [BYTE_WIDTH-1:0] w_byte_data;
  logic                  w_framing_err;
  logic [1:0]            r_byte_index;
  logic [31:0]           r_address;
  logic [31:0]           r_data;
  logic [31:0]           r_word_count;
  logic                  r_write_enabled;
  logic                  r_done;
  logic                  r_err_framing;
  logic                  r_err_overflow;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rx          (rx),
    .byte_valid  (w_byte_valid),
    .byte_data   (w_byte_data),
    .framing_err (w_framing_err)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byte_index    <= '0;
      r_address       <= '0;
      r_data          <= '0;
      r_word_count    <= '0;
      r_write_enabled <= 1'b0;
      r_done          <= 1'b0;
      r_err_framing   <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else if (!enable) begin
      r_byte_index    <= '0;
      r_address       <= '0;
      r_data          <= '0;
      r_word_count    <= '0;
      r_write_enabled <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_write_enabled <= 1'b0;
      if (w_framing_err) r_err_framing <= 1'b1;
      // Advance only after the strobe so address/data stay stable while it is high.
      if (r_write_enabled) begin
        r_address    <= r_address + 32'd1;
        r_word_count <= r_word_count + 32'd1;
        r_byte_index <= '0;
        r_done       <= (r_word_count + 32'd1 == MEM_WORDS);
      end
      if (w_byte_valid) begin
        if (r_done) begin
          r_err_overflow <= 1'b1;
        end else begin
          r_data <= {r_data[31-BYTE_WIDTH:0], w_byte_data};
          if (r_byte_index == LAST_BYTE) r_write_enabled <= 1'b1;
          else r_byte_index <= r_byte_index + 2'd1;
        end
      end
    end
  end

  assign address       = r_address;
  assign data          = r_data;
  assign write_enabled = r_write_enabled;
  assign word_count    = r_word_count;
  assign done          = r_done;
  assign err_framing   = r_err_framing;
  assign err_overflow  = r_err_overflow;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: directed vector table, multi-cycle
// corner sequences, and randomized bytes checked against a word-level model.
module tb_imem_uart_loader;

  localparam int CPB = 4;
  localparam int MEM = 43;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] address, data, word_count;
  logic        write_enabled, done, err_framing, err_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  logic [63:0] obs_q[$];

  always #5 clock = ~clock;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .MEMORY_SIZE(MEM)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rx           (rx),
    .address      (address),
    .data         (data),
    .write_enabled(write_enabled),
    .word_count   (word_count),
    .done         (done),
    .err_framing  (err_framing),
    .err_overflow (err_overflow)
  );

  always @(negedge clock) begin
    if (write_enabled === 1'b1) begin
      obs_q.push_back({address, data});
      n_strobe++;
    end
  end

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  // Word-level reference model state
  logic [63:0] exp_q[$];
  logic [31:0] m_buf;
  int          m_nb;
  int          m_count;
  logic        m_fr, m_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(6);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task automatic pulse_enable_low();
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
  endtask

  task automatic chk_one_strobe(input string name, input int base,
                                input logic [31:0] ea, input logic [31:0] ed);
    logic [63:0] last;
    last = '0;
    if (obs_q.size() > 0) last = obs_q[$];
    obs_q.delete();
    chk({name, "_strobes"}, 32'(n_strobe - base), 32'd1);
    chk({name, "_addr"}, last[63:32], ea);
    chk({name, "_data"}, last[31:0], ed);
  endtask

  task automatic model_clear();
    m_buf = '0;
    m_nb = 0;
    m_count = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) m_fr = 1'b1;
    else if (m_count == MEM) m_ov = 1'b1;
    else begin
      m_buf = {m_buf[23:0], b};
      m_nb++;
      if (m_nb == 4) begin
        exp_q.push_back({32'(m_count), m_buf});
        m_count++;
        m_nb = 0;
      end
    end
  endtask

  task automatic model_compare();
    logic [63:0] o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) chk("rand_unexpected_strobe", o[63:32], 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("rand_addr", o[63:32], e[63:32]);
        chk("rand_data", o[31:0], e[31:0]);
      end
    end
    chk("rand_missing_strobes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("rand_word_count", word_count, 32'(m_count));
    chk("rand_done", {31'd0, done}, {31'd0, m_count == MEM});
    chk("rand_err_framing", {31'd0, err_framing}, {31'd0, m_fr});
    chk("rand_err_overflow", {31'd0, err_overflow}, {31'd0, m_ov});
  endtask

  initial begin
    vec_t vecs[4];
    int   base;
    logic [7:0] rb;
    logic       rs;

    vecs[0] = '{8'h20, 8'h08, 8'h00, 8'h05, 32'd0, 32'h2008_0005};
    vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'd1, 32'hDEAD_BEEF};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'd2, 32'h0000_0001};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'd3, 32'hFF00_FF00};

    tick(3);
    chk("rst_address", address, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_we", {31'd0, write_enabled}, 32'd0);
    chk("rst_word_count", word_count, 32'd0);
    chk("rst_flags", {29'd0, done, err_framing, err_overflow}, 32'd0);
    reset = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(4);

    obs_q.delete();
    for (int v = 0; v < 4; v++) begin
      base = n_strobe;
      send_byte(vecs[v].b0, 1'b1);
      send_byte(vecs[v].b1, 1'b1);
      send_byte(vecs[v].b2, 1'b1);
      send_byte(vecs[v].b3, 1'b1);
      chk_one_strobe("vec", base, vecs[v].exp_addr, vecs[v].exp_data);
      chk("vec_word_count", word_count, vecs[v].exp_addr + 32'd1);
    end

    // Framing error, then a clean word resumes at address 0
    pulse_enable_low();
    base = n_strobe;
    send_byte(8'h11, 1'b0);
    chk("frame_err", {31'd0, err_framing}, 32'd1);
    chk("frame_no_strobe", 32'(n_strobe - base), 32'd0);
    send_word(32'hAABB_CCDD);
    chk_one_strobe("frame_resume", base, 32'd0, 32'hAABB_CCDD);

    // One-cycle glitch is rejected without error
    base = n_strobe;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(12);
    chk("glitch_no_strobe", 32'(n_strobe - base), 32'd0);
    chk("glitch_word_count", word_count, 32'd1);
    chk("glitch_no_overflow", {31'd0, err_overflow}, 32'd0);
    send_word(32'h1234_5678);
    chk_one_strobe("glitch_next", base, 32'd1, 32'h1234_5678);

    // Partial word discarded by an enable drop
    pulse_enable_low();
    base = n_strobe;
    send_byte(8'h77, 1'b1);
    send_byte(8'h66, 1'b1);
    pulse_enable_low();
    chk("drop_word_count", word_count, 32'd0);
    send_word(32'h0102_0304);
    chk_one_strobe("drop_resume", base, 32'd0, 32'h0102_0304);

    // Fill the whole memory, then overflow
    pulse_enable_low();
    obs_q.delete();
    base = n_strobe;
    for (int i = 0; i < MEM; i++) begin
      if (i == MEM - 1) begin
        chk("fill_not_done", {31'd0, done}, 32'd0);
        chk("fill_count_42", word_count, 32'(MEM - 1));
      end
      send_word(32'(i));
    end
    chk("fill_strobes", 32'(n_strobe - base), 32'(MEM));
    chk_one_strobe("fill_last", n_strobe - 1, 32'(MEM - 1), 32'h0000_002A);
    chk("fill_done", {31'd0, done}, 32'd1);
    chk("fill_word_count", word_count, 32'(MEM));
    chk("fill_address_hold", address, 32'(MEM));
    base = n_strobe;
    send_byte(8'h99, 1'b1);
    chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
    chk("ovf_no_strobe", 32'(n_strobe - base), 32'd0);
    chk("ovf_data_kept", data, 32'h0000_002A);

    // Asynchronous reset in the middle of a byte
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_address", address, 32'd0);
    chk("arst_data", data, 32'd0);
    chk("arst_word_count", word_count, 32'd0);
    chk("arst_flags", {28'd0, write_enabled, done, err_framing, err_overflow}, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(4);
    obs_q.delete();
    base = n_strobe;
    send_word(32'hCAFE_0123);
    chk_one_strobe("arst_next", base, 32'd0, 32'hCAFE_0123);

    // Randomized bytes, framing errors and enable drops vs. the model
    pulse_enable_low();
    obs_q.delete();
    exp_q.delete();
    model_clear();
    m_fr = 1'b0;
    m_ov = 1'b0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        pulse_enable_low();
        model_clear();
      end else begin
        rb = 8'($urandom);
        rs = ($urandom_range(0, 7) != 0);
        send_byte(rb, rs);
        model_byte(rb, rs);
      end
      model_compare();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
